// File: rtl/alu_control_pkg.sv
// Shared constants for the multicycle ALU control: ALU op codes, funct codes,
// ALU_op classes and the multiply/divide sequencer state type.
package alu_control_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

  // Instructions that touch HI/LO and therefore must wait for the sequencer.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU) ||
           (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/alu_control_muldiv_if.sv
// Bundle between the main control / register file and the ALU control block.
// master = control side, slave = alu_control_muldiv.
interface alu_control_muldiv_if #(parameter int WIDTH = 32);
  import alu_control_pkg::*;

  // Handshake: in_valid qualifies ALU_op/instruction/rs_val/rt_val for the
  // current cycle. A mult/div request is taken on the rising edge only while
  // the sequencer is IDLE; while stall=1 the control side must hold the same
  // request stable. done pulses for one cycle when HI/LO hold the new result.
  logic             in_valid;
  logic [1:0]       ALU_op;
  logic [5:0]       instruction;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [3:0]       op;
  logic             illegal;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_t        state;

  modport master (
    output in_valid, ALU_op, instruction, rs_val, rt_val,
    input  op, illegal, busy, stall, done, hi, lo, state
  );

  modport slave (
    input  in_valid, ALU_op, instruction, rs_val, rt_val,
    output op, illegal, busy, stall, done, hi, lo, state
  );

endinterface

// File: rtl/alu_control_muldiv_muldiv_seq.sv
// Iterative one-bit-per-cycle multiply/divide sequencer with HI/LO registers.
// MULDIV_SIGNED_EN adds magnitude/sign handling for MULT and DIV.
module muldiv_seq
  import alu_control_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
`ifdef MULDIV_SIGNED_EN
  input  logic             start_signed,
`endif
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_t        state
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             last_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_SIGNED_EN
  logic             rs_neg;
  logic             rt_neg;
  logic             rt_zero;
  logic             neg_lo;
  logic             neg_hi;

  // Divide by zero keeps the raw dividend so the unsigned datapath yields
  // lo = all ones, hi = dividend with no sign fix-up.
  always_comb begin
    rs_neg  = start_signed & rs_val[WIDTH-1];
    rt_neg  = start_signed & rt_val[WIDTH-1];
    rt_zero = (rt_val == '0);
    load_a  = (rs_neg && !(start_div && rt_zero)) ? -rs_val : rs_val;
    load_b  = rt_neg ? -rt_val : rt_val;
  end
`else
  assign load_a = rs_val;
  assign load_b = rt_val;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_mul)      next_state = MUL;
        else if (start_div) next_state = DIV;
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign last_iter = (cnt == CNT_ONE);

  // Multiply: {acc_hi, acc_lo} shifts right, multiplier consumed from acc_lo[0].
  // Divide: {acc_hi, acc_lo} shifts left, remainder in acc_hi, quotient into acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd_b});
    div_sub   = div_shift[WIDTH-1:0] - opnd_b;
    if (state == MUL) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = div_ok ? div_sub : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ok};
    end
  end

  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
`ifdef MULDIV_SIGNED_EN
    if (state == MUL) begin
      if (neg_lo) {res_hi, res_lo} = -{nxt_hi, nxt_lo};
    end else begin
      if (neg_lo) res_lo = -nxt_lo;
      if (neg_hi) res_hi = -nxt_hi;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_mul || start_div) begin
            cnt    <= CNT_INIT;
            acc_hi <= '0;
            acc_lo <= load_a;
            opnd_b <= load_b;
`ifdef MULDIV_SIGNED_EN
            neg_lo <= (rs_neg ^ rt_neg) & ~(start_div & rt_zero);
            neg_hi <= rs_neg & start_div & ~rt_zero;
`endif
          end
        end
        MUL, DIV: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt - CNT_ONE;
          if (last_iter) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU control for the multicycle MIPS core: combinational ALU_op/funct decode
// plus the HI/LO multiply/divide sequencer. Optional macro: MULDIV_SIGNED_EN.
module alu_control_muldiv
  import alu_control_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_control_muldiv_if.slave  bus
);

  logic       is_funct;
  logic       req_mul;
  logic       req_div;
  logic [3:0] op_d;
  logic       illegal_d;
  logic       seq_busy;
  logic       seq_done;
  md_state_t  seq_state;
  logic [WIDTH-1:0] seq_hi;
  logic [WIDTH-1:0] seq_lo;

  always_comb begin
    op_d      = OP_ADD;
    illegal_d = 1'b0;
    case (bus.ALU_op)
      AOP_ADD: op_d = OP_ADD;
      AOP_SUB: op_d = OP_SUB;
      AOP_OR:  op_d = OP_OR;
      default: begin
        case (bus.instruction)
          F_ADD:   op_d = OP_ADD;
          F_SUB:   op_d = OP_SUB;
          F_AND:   op_d = OP_AND;
          F_OR:    op_d = OP_OR;
          F_NOR:   op_d = OP_NOR;
          F_SLT:   op_d = OP_SLT;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO: op_d = OP_ADD;
          default: illegal_d = 1'b1;
        endcase
      end
    endcase
  end

  assign is_funct = bus.in_valid && (bus.ALU_op == AOP_FUNCT);
  assign req_mul  = is_funct && ((bus.instruction == F_MULT) || (bus.instruction == F_MULTU));
  assign req_div  = is_funct && ((bus.instruction == F_DIV)  || (bus.instruction == F_DIVU));

  muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .start_mul    (req_mul),
    .start_div    (req_div),
`ifdef MULDIV_SIGNED_EN
    .start_signed ((bus.instruction == F_MULT) || (bus.instruction == F_DIV)),
`endif
    .rs_val       (bus.rs_val),
    .rt_val       (bus.rt_val),
    .busy         (seq_busy),
    .done         (seq_done),
    .hi           (seq_hi),
    .lo           (seq_lo),
    .state        (seq_state)
  );

  // HI/LO users hold only while iterating; DONE already has the result latched.
  assign bus.stall   = seq_busy && is_funct && is_muldiv_funct(bus.instruction);
  assign bus.op      = op_d;
  assign bus.illegal = illegal_d;
  assign bus.busy    = seq_busy;
  assign bus.done    = seq_done;
  assign bus.hi      = seq_hi;
  assign bus.lo      = seq_lo;
  assign bus.state   = seq_state;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Self-checking bench for alu_control_muldiv: decode sweep, mult/div latency,
// stall behaviour, boundary operands and mid-operation reset.
module tb_alu_control_muldiv;
  import alu_control_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [2*W-1:0] exp_q[$];

  alu_control_muldiv_if #(.WIDTH(W)) bus();

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo} for a mult/div funct.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [63:0] r;
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    if (f == F_MULT || f == F_MULTU) begin
      if (SIGNED_EN && f == F_MULT) r = 64'(sa * sb);
      else                          r = {32'b0, a} * {32'b0, b};
    end else if (b == '0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (SIGNED_EN && f == F_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_val("hi", 64'(bus.hi), 64'(e[63:32]));
        check_val("lo", 64'(bus.lo), 64'(e[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.in_valid    = 1'b0;
    bus.ALU_op      = 2'b00;
    bus.instruction = 6'b000000;
    bus.rs_val      = '0;
    bus.rt_val      = '0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check_val("done_timeout", 64'(seen), 64'd1);
  endtask

  // Called only when the sequencer is idle: request is taken on the next edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.ALU_op      = AOP_FUNCT;
    bus.instruction = f;
    bus.rs_val      = a;
    bus.rt_val      = b;
    exp_q.push_back(model(f, a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done();
  endtask

  task automatic dec(input logic [1:0] aop, input logic [5:0] f,
                     input logic [3:0] exp_op, input logic exp_ill);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.ALU_op      = aop;
    bus.instruction = f;
    #1;
    check_val("op", 64'(bus.op), 64'(exp_op));
    check_val("illegal", 64'(bus.illegal), 64'(exp_ill));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_stall", 64'(bus.stall), 64'd0);
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);
    check_val("rst_state", 64'(bus.state), 64'(IDLE));

    // Decode sweep
    dec(2'b00, 6'b000000, 4'b0010, 1'b0);
    dec(2'b01, 6'b000000, 4'b0110, 1'b0);
    dec(2'b11, 6'b000000, 4'b0001, 1'b0);
    dec(2'b10, 6'b100000, 4'b0010, 1'b0);
    dec(2'b10, 6'b100010, 4'b0110, 1'b0);
    dec(2'b10, 6'b100100, 4'b0000, 1'b0);
    dec(2'b10, 6'b100101, 4'b0001, 1'b0);
    dec(2'b10, 6'b100111, 4'b1100, 1'b0);
    dec(2'b10, 6'b101010, 4'b0111, 1'b0);
    dec(2'b10, 6'b000101, 4'b0010, 1'b1);
    dec(2'b10, 6'b011000, 4'b0010, 1'b0);
    dec(2'b10, 6'b010010, 4'b0010, 1'b0);
    dec(2'b00, 6'b000101, 4'b0010, 1'b0);
    drive_idle();

    // MULTU 7x6: latency, stall window, re-issue after DONE
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.ALU_op      = AOP_FUNCT;
    bus.instruction = F_MULTU;
    bus.rs_val      = 32'd7;
    bus.rt_val      = 32'd6;
    exp_q.push_back(model(F_MULTU, 32'd7, 32'd6));
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
      if (c == 3) begin
        bus.in_valid    = 1'b1;
        bus.instruction = F_SUB;
      end
      if (c == 4) bus.in_valid = 1'b0;
      if (c == 5) begin
        bus.in_valid    = 1'b1;
        bus.instruction = F_MULTU;
        bus.rs_val      = 32'd3;
        bus.rt_val      = 32'd4;
      end
      #1;
      check_val($sformatf("busy_c%0d", c), 64'(bus.busy), 64'(c <= W));
      check_val($sformatf("done_c%0d", c), 64'(bus.done), 64'(c == W + 1));
      check_val($sformatf("stall_c%0d", c), 64'(bus.stall), 64'(c >= 5 && c <= W));
      if (c == 3) check_val("op_while_busy", 64'(bus.op), 64'(OP_SUB));
      if (c == W + 2) exp_q.push_back(model(F_MULTU, 32'd3, 32'd4));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_val("reissue_busy", 64'(bus.busy), 64'd1);
    wait_done();

    // Boundary operands
    issue(F_DIVU, 32'd100, 32'd7);
    issue(F_DIVU, 32'd5, 32'd0);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_DIVU, 32'h8000_0000, 32'd1);
    issue(F_DIVU, 32'd3, 32'd9);

    // Random unsigned operands
    for (int i = 0; i < 4; i++) begin
      issue(F_MULTU, $urandom, $urandom);
      issue(F_DIVU, $urandom, $urandom_range(1, 32'hFFFF));
    end

    // Reset during a DIVU: abort, clear HI/LO, no done pulse
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.ALU_op      = AOP_FUNCT;
    bus.instruction = F_DIVU;
    bus.rs_val      = 32'd1000;
    bus.rt_val      = 32'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_hi", 64'(bus.hi), 64'd0);
    check_val("abort_lo", 64'(bus.lo), 64'd0);
    check_val("abort_done", 64'(bus.done), 64'd0);
    repeat (W + 4) @(negedge clk);
    issue(F_MULTU, 32'd3, 32'd3);

    // Signed funct codes (sign handling only with MULDIV_SIGNED_EN)
    issue(F_MULT, 32'hFFFF_FFFD, 32'd5);
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(F_DIV, 32'hFFFF_FFF9, 32'd0);
    issue(F_DIV, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      issue(F_MULT, $urandom, $urandom);
      issue(F_DIV, $urandom, $urandom_range(1, 32'hFFFF));
    end

    repeat (3) @(negedge clk);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
